alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width.
REQ-002 SHALL have parameter IWIDTH, default 8, op_code width.
REQ-003 SHALL have parameter AWIDTH, default 8, destination address width.
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum number of cycles to wait for mem_ack.
REQ-005 SHALL have ports clk (in, 1, clock) and rst (in, 1, asynchronous active-high reset); one clock; reset asynchronous, active-high.
REQ-006 SHALL have in_valid (in, 1) and in_ready (out, 1); transfer occurs when both are high at a clk rising edge.
REQ-007 SHALL have op_code (in, IWIDTH), alu_out (in, WIDTH), alu_c_out (in, 1), alu_b_out (in, 1) and alu_flag_valid (in, 1), the ALU result bundle.
REQ-008 SHALL have dest_sel (in, 2; 00 rf, 01 bit mem, 10 word mem, 11 none) and dest_addr (in, AWIDTH).
REQ-009 SHALL have outputs acc (WIDTH, current result), c_flag (1) and b_flag (1), fed back to ALU rf_a/alu_c_in/alu_b_in.
REQ-010 SHALL have rf_we (out, 1), rf_waddr (out, AWIDTH) and rf_wdata (out, WIDTH).
REQ-011 SHALL have mem_req, mem_bit (out, 1; 1 bit access, 0 word access), mem_addr (AWIDTH), mem_wdata (WIDTH) and mem_ack (in, 1).
REQ-012 SHALL have err_timeout (out, 1), a sticky error flag.

Function
REQ-013 SHALL classify 0x1D ST, 0x1E STN, 0x1B S and 0x1C R as store ops; all other op_codes are accumulate ops.
REQ-014 An accumulate op SHALL load acc <= alu_out at the accepting edge; it SHALL NOT write to rf or memory.
REQ-015 When alu_flag_valid=1 at acceptance, c_flag <= alu_c_out and b_flag <= alu_b_out; otherwise both SHALL hold.
REQ-016 ST/STN SHALL write alu_out to the destination unconditionally; S/R SHALL write only if acc[0]=1, and are otherwise dropped in 1 cycle.
REQ-017 Bit-memory writes SHALL carry only alu_out[0] in mem_wdata[0], with the upper bits zero.
REQ-018 FSM states SHALL be IDLE, RF_WR, MEM_WAIT and ERR.
REQ-019 IDLE: in_ready=1; a store with dest_sel=00 goes to RF_WR; with 01/10 goes to MEM_WAIT; with 11 stays in IDLE.
REQ-020 RF_WR SHALL assert rf_we for exactly one cycle with the captured addr/data, then return to IDLE; in_ready=0.
REQ-021 MEM_WAIT SHALL hold mem_req=1 and mem_addr/mem_wdata/mem_bit stable until mem_ack is sampled high, then return to IDLE next cycle; in_ready=0.
REQ-022 mem_ack SHALL be ignored outside MEM_WAIT.
REQ-023 Accumulate-op latency SHALL be 1 cycle; store-to-rf latency 2 cycles; a store-to-memory transaction occupies 1+N cycles, where N is the number of ack-wait cycles.
REQ-024 All outputs SHALL be registered; in_ready is combinational from state only.

Reset
REQ-025 On rst: state=IDLE; acc=0; c_flag=0; b_flag=0; rf_we=0; mem_req=0; all address/data outputs 0; err_timeout=0.
REQ-026 rst asserted during MEM_WAIT SHALL drop mem_req immediately (asynchronous) and abandon the transaction.

Configuration
REQ-027 Macro WB_ACK_TIMEOUT_EN SHALL compile in a counter that counts MEM_WAIT cycles; reaching TIMEOUT without mem_ack moves the FSM to ERR, drops mem_req and sets err_timeout.
REQ-028 In ERR, in_ready=0 until rst; err_timeout SHALL clear only on rst.
REQ-029 Without WB_ACK_TIMEOUT_EN: no counter, no ERR state reachable, err_timeout tied 0, and MEM_WAIT waits indefinitely.

Structure
REQ-030 A shared package SHALL hold the op_code localparams (ST, STN, S, R and the ALU set), the dest_sel encoding enum and the FSM state enum.
REQ-031 The timeout counter SHALL be a sub-module wb_timeout_cnt, instantiated only under WB_ACK_TIMEOUT_EN.

Verification
REQ-032 op 0x07, alu_out=0x3C, alu_c_out=1, flag_valid=1 -> next edge acc=0x3C, c_flag=1, no writes.
REQ-033 op 0x1D, dest_sel=00, addr=0x05, alu_out=0xA5 -> rf_we pulses 1 cycle with waddr=0x05, wdata=0xA5; in_ready low that cycle.
REQ-034 op 0x1B, acc=0x00, dest_sel=01 -> no mem_req; in_ready stays 1. The same op with acc=0x01 -> mem_req, mem_bit=1, mem_wdata=0x01.
REQ-035 op 0x1E, dest_sel=10, mem_ack delayed 3 cycles -> mem_req high exactly 4 cycles, with addr/data stable throughout.
REQ-036 With WB_ACK_TIMEOUT_EN and TIMEOUT=15, no ack -> after 15 MEM_WAIT cycles mem_req=0, err_timeout=1, in_ready=0; rst clears all.
REQ-037 rst pulsed mid-MEM_WAIT -> mem_req=0 before the next edge; the next transfer proceeds normally.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback stage: op_code values, destination encoding, FSM states.
// Optional ack timeout is enabled with the WB_ACK_TIMEOUT_EN macro (see alu_writeback.sv).
package alu_writeback_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LD  = 8'h01;
  localparam logic [7:0] OP_AND = 8'h02;
  localparam logic [7:0] OP_OR  = 8'h03;
  localparam logic [7:0] OP_XOR = 8'h04;
  localparam logic [7:0] OP_ADD = 8'h05;
  localparam logic [7:0] OP_SUB = 8'h06;
  localparam logic [7:0] OP_LDN = 8'h07;

  // Store ops; S and R are conditional on acc[0]
  localparam logic [7:0] OP_S   = 8'h1B;
  localparam logic [7:0] OP_R   = 8'h1C;
  localparam logic [7:0] OP_ST  = 8'h1D;
  localparam logic [7:0] OP_STN = 8'h1E;

  typedef enum logic [1:0] {
    DEST_RF   = 2'b00,
    DEST_BIT  = 2'b01,
    DEST_WORD = 2'b10,
    DEST_NONE = 2'b11
  } dest_e;

  typedef enum logic [1:0] {
    WB_IDLE     = 2'b00,
    WB_RF_WR    = 2'b01,
    WB_MEM_WAIT = 2'b10,
    WB_ERR      = 2'b11
  } wb_state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Down-counter for memory-ack wait cycles; o_tc flags the last allowed wait cycle.
// Instantiated only when WB_ACK_TIMEOUT_EN is defined.
module wb_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Loaded with TIMEOUT-1 so terminal count lands on the TIMEOUT-th wait cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(TIMEOUT - 1);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/alu_writeback.sv
// ALU result writeback: accumulates into acc/flags or stores to register file / bit or word memory.
// Define WB_ACK_TIMEOUT_EN to add a mem_ack timeout that parks the FSM in ERR with err_timeout set.
//
// state    | meaning
// IDLE     | ready for a new ALU result
// RF_WR    | rf_we pulse with captured address/data
// MEM_WAIT | mem_req held until mem_ack
// ERR      | ack timeout, stalled until rst
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int IWIDTH  = 8,
  parameter int AWIDTH  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IWIDTH-1:0] op_code,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_c_out,
  input  logic              alu_b_out,
  input  logic              alu_flag_valid,
  input  logic [1:0]        dest_sel,
  input  logic [AWIDTH-1:0] dest_addr,
  output logic [WIDTH-1:0]  acc,
  output logic              c_flag,
  output logic              b_flag,
  output logic              rf_we,
  output logic [AWIDTH-1:0] rf_waddr,
  output logic [WIDTH-1:0]  rf_wdata,
  output logic              mem_req,
  output logic              mem_bit,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic              mem_ack,
  output logic              err_timeout
);
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("alu_writeback: TIMEOUT must be at least 1");
  end

  wb_state_e r_state, w_state_nxt;
  dest_e     w_dest;
  logic      w_accept, w_uncond, w_is_store, w_go, w_to_tc;

  assign w_dest     = dest_e'(dest_sel);
  assign in_ready   = (r_state == WB_IDLE);
  assign w_accept   = in_valid && in_ready;
  assign w_uncond   = (op_code == IWIDTH'(OP_ST)) || (op_code == IWIDTH'(OP_STN));
  assign w_is_store = w_uncond || (op_code == IWIDTH'(OP_S)) || (op_code == IWIDTH'(OP_R));
  assign w_go       = w_accept && w_is_store && (w_uncond || acc[0]);

`ifdef WB_ACK_TIMEOUT_EN
  logic w_to_load;
  assign w_to_load = (r_state == WB_IDLE) && (w_state_nxt == WB_MEM_WAIT);

  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_to_load),
    .i_en   (r_state == WB_MEM_WAIT),
    .o_tc   (w_to_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_timeout <= 1'b0;
    end else if ((r_state == WB_MEM_WAIT) && (w_state_nxt == WB_ERR)) begin
      err_timeout <= 1'b1;
    end
  end
`else
  assign w_to_tc     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WB_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WB_IDLE: begin
        if (w_go) begin
          case (w_dest)
            DEST_RF:             w_state_nxt = WB_RF_WR;
            DEST_BIT, DEST_WORD: w_state_nxt = WB_MEM_WAIT;
            default:             w_state_nxt = WB_IDLE;
          endcase
        end
      end
      WB_RF_WR:    w_state_nxt = WB_IDLE;
      WB_MEM_WAIT: begin
        // A late ack still wins over the timeout on the same edge
        if (mem_ack)      w_state_nxt = WB_IDLE;
        else if (w_to_tc) w_state_nxt = WB_ERR;
      end
      default:     w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      c_flag    <= 1'b0;
      b_flag    <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      mem_req   <= 1'b0;
      mem_bit   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      rf_we <= 1'b0;
      if (w_accept) begin
        if (!w_is_store) acc <= alu_out;
        if (alu_flag_valid) begin
          c_flag <= alu_c_out;
          b_flag <= alu_b_out;
        end
      end
      if ((r_state == WB_IDLE) && (w_state_nxt == WB_RF_WR)) begin
        rf_we    <= 1'b1;
        rf_waddr <= dest_addr;
        rf_wdata <= alu_out;
      end
      if ((r_state == WB_IDLE) && (w_state_nxt == WB_MEM_WAIT)) begin
        mem_req   <= 1'b1;
        mem_bit   <= (w_dest == DEST_BIT);
        mem_addr  <= dest_addr;
        mem_wdata <= (w_dest == DEST_BIT) ? WIDTH'(alu_out[0]) : alu_out;
      end
      if ((r_state == WB_MEM_WAIT) && (w_state_nxt != WB_MEM_WAIT)) begin
        mem_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback; checks sampled 1ns after each rising edge.
// The ack-timeout section follows WB_ACK_TIMEOUT_EN so the bench matches either build.
module tb_alu_writeback;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_code;
  logic [7:0] alu_out;
  logic       alu_c_out, alu_b_out, alu_flag_valid;
  logic [1:0] dest_sel;
  logic [7:0] dest_addr;
  logic [7:0] acc;
  logic       c_flag, b_flag;
  logic       rf_we;
  logic [7:0] rf_waddr, rf_wdata;
  logic       mem_req, mem_bit;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_ack;
  logic       err_timeout;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  alu_writeback #(.WIDTH(8), .IWIDTH(8), .AWIDTH(8), .TIMEOUT(15)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .op_code        (op_code),
    .alu_out        (alu_out),
    .alu_c_out      (alu_c_out),
    .alu_b_out      (alu_b_out),
    .alu_flag_valid (alu_flag_valid),
    .dest_sel       (dest_sel),
    .dest_addr      (dest_addr),
    .acc            (acc),
    .c_flag         (c_flag),
    .b_flag         (b_flag),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .mem_req        (mem_req),
    .mem_bit        (mem_bit),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .err_timeout    (err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] op, input logic [7:0] dat,
                       input logic c, input logic b, input logic fv,
                       input logic [1:0] ds, input logic [7:0] da);
    in_valid       = v;
    op_code        = op;
    alu_out        = dat;
    alu_c_out      = c;
    alu_b_out      = b;
    alu_flag_valid = fv;
    dest_sel       = ds;
    dest_addr      = da;
  endtask

  initial begin
    int cnt;
    rst     = 1'b1;
    mem_ack = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    tick();
    tick();
    chk("rst_acc", acc, 8'h00);
    chk("rst_c", c_flag, 1'b0);
    chk("rst_b", b_flag, 1'b0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_rf_waddr", rf_waddr, 8'h00);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    rst = 1'b0;

    // Accumulate with flags
    drive(1'b1, 8'h07, 8'h3C, 1'b1, 1'b0, 1'b1, 2'b00, 8'h10);
    tick();
    chk("acc_load", acc, 8'h3C);
    chk("acc_c", c_flag, 1'b1);
    chk("acc_b", b_flag, 1'b0);
    chk("acc_no_rf", rf_we, 1'b0);
    chk("acc_no_mem", mem_req, 1'b0);

    // Accumulate without flag update: flags hold
    drive(1'b1, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 2'b01, 8'h10);
    tick();
    chk("acc_zero", acc, 8'h00);
    chk("hold_c", c_flag, 1'b1);
    chk("hold_b", b_flag, 1'b0);

    // S with acc[0]=0 is dropped
    drive(1'b1, 8'h1B, 8'hFF, 1'b0, 1'b0, 1'b0, 2'b01, 8'h11);
    tick();
    chk("s_drop_req", mem_req, 1'b0);
    chk("s_drop_ready", in_ready, 1'b1);
    chk("s_drop_acc", acc, 8'h00);

    drive(1'b1, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1, 2'b00, 8'h00);
    tick();
    chk("acc_one", acc, 8'h01);
    chk("flag_c0", c_flag, 1'b0);
    chk("flag_b1", b_flag, 1'b1);

    // S with acc[0]=1 to bit memory
    drive(1'b1, 8'h1B, 8'hFE, 1'b0, 1'b0, 1'b0, 2'b01, 8'h22);
    tick();
    chk("s_bit_req", mem_req, 1'b1);
    chk("s_bit_bit", mem_bit, 1'b1);
    chk("s_bit_wdata", mem_wdata, 8'h00);
    chk("s_bit_addr", mem_addr, 8'h22);
    chk("s_bit_ready", in_ready, 1'b0);
    drive(1'b1, 8'h1B, 8'h01, 1'b0, 1'b0, 1'b0, 2'b01, 8'h23);
    mem_ack = 1'b1;
    tick();
    chk("s_bit_done", mem_req, 1'b0);
    chk("s_bit_idle", in_ready, 1'b1);
    chk("s_bit2_req", mem_req, 1'b0);

    // Same op again, alu_out[0]=1
    tick();
    chk("s_bit2_req_hi", mem_req, 1'b1);
    chk("s_bit2_wdata", mem_wdata, 8'h01);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    tick();
    chk("s_bit2_done", mem_req, 1'b0);

    // Ack outside MEM_WAIT is ignored
    tick();
    chk("ack_ignored_req", mem_req, 1'b0);
    chk("ack_ignored_ready", in_ready, 1'b1);
    mem_ack = 1'b0;

    // ST to register file
    drive(1'b1, 8'h1D, 8'hA5, 1'b0, 1'b0, 1'b0, 2'b00, 8'h05);
    tick();
    chk("st_rf_we", rf_we, 1'b1);
    chk("st_rf_waddr", rf_waddr, 8'h05);
    chk("st_rf_wdata", rf_wdata, 8'hA5);
    chk("st_rf_ready", in_ready, 1'b0);
    chk("st_rf_acc", acc, 8'h01);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    tick();
    chk("st_rf_we_off", rf_we, 1'b0);
    chk("st_rf_ready2", in_ready, 1'b1);

    // R with dest none: no write anywhere
    drive(1'b1, 8'h1C, 8'h55, 1'b0, 1'b0, 1'b0, 2'b11, 8'h07);
    tick();
    chk("none_rf_we", rf_we, 1'b0);
    chk("none_req", mem_req, 1'b0);
    chk("none_ready", in_ready, 1'b1);

    // STN to word memory, ack arrives in the 4th request cycle
    drive(1'b1, 8'h1E, 8'h5A, 1'b0, 1'b0, 1'b0, 2'b10, 8'h40);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 8'hFF);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req === 1'b1) cnt++;
      chk("stn_addr", mem_addr, 8'h40);
      chk("stn_wdata", mem_wdata, 8'h5A);
      chk("stn_bit", mem_bit, 1'b0);
      if (i == 3) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("stn_req_cycles", cnt, 4);
    chk("stn_req_off", mem_req, 1'b0);
    chk("stn_ready", in_ready, 1'b1);

    // Reset in the middle of MEM_WAIT
    drive(1'b1, 8'h1D, 8'h77, 1'b0, 1'b0, 1'b0, 2'b10, 8'h33);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    tick();
    chk("mid_req_hi", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", mem_req, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_acc", acc, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'h02, 8'h81, 1'b1, 1'b1, 1'b0, 2'b00, 8'h00);
    tick();
    chk("post_rst_acc", acc, 8'h81);
    chk("post_rst_c", c_flag, 1'b0);
    drive(1'b1, 8'h1D, 8'h3F, 1'b0, 1'b0, 1'b0, 2'b00, 8'h09);
    tick();
    chk("post_rst_rf_we", rf_we, 1'b1);
    chk("post_rst_waddr", rf_waddr, 8'h09);
    chk("post_rst_wdata", rf_wdata, 8'h3F);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    tick();

    // No ack at all
    drive(1'b1, 8'h1D, 8'hC3, 1'b0, 1'b0, 1'b0, 2'b10, 8'h44);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    cnt = 0;
`ifdef WB_ACK_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      if (mem_req !== 1'b1) break;
      cnt++;
      tick();
    end
    chk("to_req_cycles", cnt, 15);
    chk("to_req_off", mem_req, 1'b0);
    chk("to_err", err_timeout, 1'b1);
    chk("to_ready", in_ready, 1'b0);
    drive(1'b1, 8'h01, 8'h99, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    mem_ack = 1'b1;
    tick();
    chk("err_stall_acc", acc, 8'h81);
    chk("err_sticky", err_timeout, 1'b1);
    chk("err_ready", in_ready, 1'b0);
    mem_ack = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    rst = 1'b1;
    tick();
    chk("err_rst_clr", err_timeout, 1'b0);
    chk("err_rst_ready", in_ready, 1'b1);
    chk("err_rst_acc", acc, 8'h00);
    rst = 1'b0;
`else
    for (int i = 0; i < 20; i++) begin
      if (mem_req === 1'b1) cnt++;
      tick();
    end
    chk("wait_req_cycles", cnt, 20);
    chk("wait_err", err_timeout, 1'b0);
    chk("wait_ready", in_ready, 1'b0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("wait_req_off", mem_req, 1'b0);
    chk("wait_ready2", in_ready, 1'b1);
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
